// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo slice: default geometry/levels, depth
// derivation and the transfer/flag types used by the pointer and count logic.
package sync_fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned FIFO_ADDR_WIDTH = 5;
    localparam int unsigned FIFO_AF_LEVEL   = 28;
    localparam int unsigned FIFO_AE_LEVEL   = 4;

    // Encodes {write accepted, read accepted} for the occupancy update.
    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_RD   = 2'b01,
        XFER_WR   = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port and one registered read port on the
// same clock. The array itself is never reset; only the read register is.
module fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; holds its value when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO: pointer management, occupancy count,
// registered full/empty/almost flags and overflow/underflow pulses.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = FIFO_AF_LEVEL,
    parameter int unsigned AE_LEVEL   = FIFO_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);

    // Pointers carry one extra bit so wrap-around is plain modulo arithmetic.
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fifo_flags_t   flags_q, flags_d;
    logic          rvalid_q, overflow_q, underflow_q;
    logic          wr_acc_s, rd_acc_s;
    xfer_e         xfer_s;

    // Acceptance, next pointers, next count and flags derived from that count.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        xfer_s   = XFER_NONE;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        flags_d  = flags_q;

        wr_acc_s = wr_en & ~flags_q.full;
        rd_acc_s = rd_en & ~flags_q.empty;
        xfer_s   = xfer_e'({wr_acc_s, rd_acc_s});

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case (xfer_s)
            XFER_WR: count_d = count_q + ONE_C;
            XFER_RD: count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        flags_d.full         = (count_d == DEPTH_C);
        flags_d.empty        = (count_d == ZERO_C);
        flags_d.almost_full  = (count_d >= AF_C);
        flags_d.almost_empty = (count_d <= AE_C);
    end

    // Pointer, count, flag and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= ZERO_C;
            rd_ptr_q    <= ZERO_C;
            count_q     <= ZERO_C;
            flags_q     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            flags_q     <= flags_d;
            rvalid_q    <= rd_acc_s;
            overflow_q  <= wr_en & flags_q.full;
            underflow_q <= rd_en & flags_q.empty;
        end
    end

    // Read and write can only share an address when full or empty, and in
    // both of those cases one of the two requests is refused.
    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc_s),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wdata),
        .re_i    (rd_acc_s),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (rdata)
    );

    assign rvalid       = rvalid_q;
    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (default parameters): queue-based reference
// model compared every cycle, plus directed vectors with literal expectations.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wdata;
    logic          rd_en;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an unbounded queue limited to DEPTH entries.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rdata = '0;
    bit            exp_rvalid = 1'b0;
    bit            exp_ovf = 1'b0;
    bit            exp_unf = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int sz;
        if (!rst_n) begin
            q.delete();
            exp_rdata  = '0;
            exp_rvalid = 1'b0;
            exp_ovf    = 1'b0;
            exp_unf    = 1'b0;
        end else begin
            sz         = q.size();
            exp_ovf    = wr_en && (sz == DEPTH);
            exp_unf    = rd_en && (sz == 0);
            exp_rvalid = rd_en && (sz != 0);
            if (exp_rvalid) exp_rdata = q.pop_front();
            if (wr_en && (sz != DEPTH)) q.push_back(wdata);
        end
    end

    task automatic compare_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ".count"},     32'(count),        32'(sz));
        chk({tag, ".full"},      32'(full),         32'(sz == DEPTH));
        chk({tag, ".empty"},     32'(empty),        32'(sz == 0));
        chk({tag, ".afull"},     32'(almost_full),  32'(sz >= AF));
        chk({tag, ".aempty"},    32'(almost_empty), 32'(sz <= AE));
        chk({tag, ".rvalid"},    32'(rvalid),       32'(exp_rvalid));
        chk({tag, ".rdata"},     32'(rdata),        32'(exp_rdata));
        chk({tag, ".overflow"},  32'(overflow),     32'(exp_ovf));
        chk({tag, ".underflow"}, 32'(underflow),    32'(exp_unf));
    endtask

    always @(negedge clk) begin
        if (chk_en) compare_all("model");
    end

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en = w;
        wdata = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.aempty", 32'(almost_empty), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.rdata", 32'(rdata), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Three writes then three reads.
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        chk("basic.count3", 32'(count), 32'd3);
        step(1'b0, 8'h00, 1'b1);
        chk("basic.rv1", 32'(rvalid), 32'd1);
        chk("basic.rd1", 32'(rdata), 32'h11);
        step(1'b0, 8'h00, 1'b1);
        chk("basic.rd2", 32'(rdata), 32'h22);
        step(1'b0, 8'h00, 1'b1);
        chk("basic.rd3", 32'(rdata), 32'h33);
        chk("basic.count0", 32'(count), 32'd0);
        chk("basic.empty", 32'(empty), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        chk("basic.rv_off", 32'(rvalid), 32'd0);

        // Fill to full, then one write too many.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0);
            if (i + 1 == 27) chk("fill.af27", 32'(almost_full), 32'd0);
            if (i + 1 == 28) chk("fill.af28", 32'(almost_full), 32'd1);
        end
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.count", 32'(count), 32'd32);
        step(1'b1, 8'hEE, 1'b0);
        chk("ovf.pulse", 32'(overflow), 32'd1);
        chk("ovf.count", 32'(count), 32'd32);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf.clear", 32'(overflow), 32'd0);

        // Full with simultaneous read and write.
        step(1'b1, 8'hEF, 1'b1);
        chk("fullrw.count", 32'(count), 32'd31);
        chk("fullrw.ovf", 32'(overflow), 32'd1);
        chk("fullrw.rdata", 32'(rdata), 32'h40);
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain.rdata", 32'(rdata), 32'(8'(8'h41 + i)));
        end
        chk("drain.empty", 32'(empty), 32'd1);

        // Read while empty.
        step(1'b0, 8'h00, 1'b1);
        chk("unf.pulse", 32'(underflow), 32'd1);
        chk("unf.rvalid", 32'(rvalid), 32'd0);
        chk("unf.count", 32'(count), 32'd0);
        chk("unf.rdata", 32'(rdata), 32'h5F);

        // Empty with simultaneous read and write: no fall-through.
        step(1'b1, 8'h77, 1'b1);
        chk("emptyrw.count", 32'(count), 32'd1);
        chk("emptyrw.unf", 32'(underflow), 32'd1);
        chk("emptyrw.rvalid", 32'(rvalid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("emptyrw.rdata", 32'(rdata), 32'h77);

        // Steady state at count 10 with pointers wrapping.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h90 + i), 1'b1);
            chk("steady.count", 32'(count), 32'd10);
            chk("steady.rdata", 32'(rdata), (i < 10) ? 32'(8'(8'h80 + i)) : 32'(8'(8'h90 + i - 10)));
        end
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of a burst at count 17.
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        chk("burst.count", 32'(count), 32'd17);
        wr_en = 1'b1;
        wdata = 8'hD0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.empty", 32'(empty), 32'd1);
        chk("arst.aempty", 32'(almost_empty), 32'd1);
        chk("arst.rdata", 32'(rdata), 32'h0);
        chk("arst.rvalid", 32'(rvalid), 32'd0);
        wr_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("post.rvalid", 32'(rvalid), 32'd1);
        chk("post.rdata", 32'(rdata), 32'hA5);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
